// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register access sequencer.
package reg_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  // Cycles from the r_en issue cycle until read data lands in the FIFO.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/reg_access_sequencer_if.sv
// Host-side command/response handshake bundle for the register access sequencer.
interface reg_access_sequencer_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/reg_seq_rsp_fifo.sv
// Circular response buffer; pointers carry one extra wrap bit for full/empty.
module reg_seq_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// Drives a read-before-write register stage from host commands and returns
// captured read data through a small credit-protected response FIFO.
module reg_access_sequencer
  import reg_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RSP_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_access_sequencer_if.slave  host,
  output logic                   reg_rst,
  output logic                   reg_w_en,
  output logic                   reg_r_en,
  output logic [WIDTH-1:0]       reg_in,
  input  logic [WIDTH-1:0]       reg_out,
  output logic                   busy
);

  localparam int AW = $clog2(RSP_DEPTH);

  op_e          op;
  logic         hs, is_rd, is_wr;
  logic         reset_hold;
  logic         rd_p1, rd_p2;
  logic [AW:0]  fifo_count;
  logic         fifo_full, fifo_empty;
  logic [AW+1:0] credit;

  assign op    = op_e'(host.cmd_op);
  assign hs    = host.cmd_valid && host.cmd_ready;
  assign is_rd = (op == OP_READ)  || (op == OP_SWAP);
  assign is_wr = (op == OP_WRITE) || (op == OP_SWAP);

  // Reserve a FIFO slot for every read in flight so a push always finds room.
  assign credit         = {1'b0, fifo_count} + (AW+2)'(rd_p1) + (AW+2)'(rd_p2);
  assign host.cmd_ready = !reset_hold && (credit < (AW+2)'(RSP_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reset_hold <= 1'b1;
      reg_rst    <= 1'b1;
      reg_w_en   <= 1'b0;
      reg_r_en   <= 1'b0;
      reg_in     <= '0;
      rd_p1      <= 1'b0;
      rd_p2      <= 1'b0;
    end else begin
      reset_hold <= 1'b0;
      reg_rst    <= hs && (op == OP_CLEAR);
      reg_w_en   <= hs && is_wr;
      reg_r_en   <= hs && is_rd;
      if (hs && is_wr) reg_in <= host.cmd_data;
      rd_p1      <= hs && is_rd;
      rd_p2      <= rd_p1;
    end
  end

  reg_seq_rsp_fifo #(.WIDTH(WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_p2 && !fifo_full),
    .pop   (host.rsp_ready),
    .din   (reg_out),
    .dout  (host.rsp_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign host.rsp_valid = !fifo_empty;
  assign busy           = rd_p1 | rd_p2 | !fifo_empty;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Self-checking bench: behavioural register stage plus an in-order response scoreboard.
module tb_reg_access_sequencer;
  import reg_seq_pkg::*;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             reg_rst, reg_w_en, reg_r_en, busy;
  logic [WIDTH-1:0] reg_in;
  logic [WIDTH-1:0] reg_out;
  logic [WIDTH-1:0] reg_q;

  int vectors = 0;
  int miscompares = 0;
  bit rand_mode = 1'b0;
  logic [WIDTH-1:0] model_q = '0;
  logic [WIDTH-1:0] exp_q [$];

  reg_access_sequencer_if #(.WIDTH(WIDTH)) bus ();

  reg_access_sequencer #(.WIDTH(WIDTH), .RSP_DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .host     (bus.slave),
    .reg_rst  (reg_rst),
    .reg_w_en (reg_w_en),
    .reg_r_en (reg_r_en),
    .reg_in   (reg_in),
    .reg_out  (reg_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Register stage: read-before-write, sync clear, out is X unless read last edge.
  always @(posedge clk) begin
    reg_out <= reg_r_en ? reg_q : 'x;
    if (reg_rst)       reg_q <= '0;
    else if (reg_w_en) reg_q <= reg_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (dut.rd_p2) begin
        chk("rd_x", 32'($isunknown(reg_out)), 32'd0);
        chk("ovf", 32'(dut.fifo_full), 32'd0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("unexp_rsp", 32'd1, 32'd0);
        else chk("rsp", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic accept(input logic [1:0] op, input logic [WIDTH-1:0] d);
    case (op_e'(op))
      OP_CLEAR: model_q = '0;
      OP_WRITE: model_q = d;
      OP_READ:  exp_q.push_back(model_q);
      OP_SWAP: begin exp_q.push_back(model_q); model_q = d; end
      default: ;
    endcase
  endtask

  // Returns just after the accepting edge (the issue cycle).
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d);
    bit rdy;
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    do begin
      if (rand_mode) bus.rsp_ready = 1'($urandom_range(0, 1));
      rdy = bus.cmd_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 500);
    if (rdy) accept(op, d);
    else chk("cmd_timeout", 32'd0, 32'd1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.rsp_ready = 1'b1;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_q", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_rst", 32'(reg_rst), 32'd1);
    chk("rst_w_en", 32'(reg_w_en), 32'd0);
    chk("rst_r_en", 32'(reg_r_en), 32'd0);
    chk("rst_reg_in", 32'(reg_in), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("rel1_reg_rst", 32'(reg_rst), 32'd1);
    chk("rel1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("rel2_reg_rst", 32'(reg_rst), 32'd0);
    chk("rel2_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // WRITE then READ with latency check
    send(2'(OP_WRITE), 8'hA5);
    chk("wr_w_en", 32'(reg_w_en), 32'd1);
    chk("wr_reg_in", 32'(reg_in), 32'hA5);
    send(2'(OP_READ), 8'h00);
    chk("rd_r_en", 32'(reg_r_en), 32'd1);
    chk("rd_w_en", 32'(reg_w_en), 32'd0);
    @(posedge clk); #1;
    chk("lat_e1_valid", 32'(bus.rsp_valid), 32'd0);
    chk("lat_e1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("lat_e2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("lat_e2_data", 32'(bus.rsp_data), 32'hA5);
    drain();

    // SWAP returns the old value
    send(2'(OP_WRITE), 8'h3C);
    send(2'(OP_SWAP), 8'h81);
    chk("swap_en", 32'({reg_r_en, reg_w_en}), 32'd3);
    chk("swap_in", 32'(reg_in), 32'h81);
    send(2'(OP_READ), 8'h00);
    drain();

    // Credit backpressure with rsp_ready held low
    bus.rsp_ready = 1'b0;
    send(2'(OP_READ), 8'h00);
    send(2'(OP_READ), 8'h00);
    chk("bp_ready_drop", 32'(bus.cmd_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ready_hold", 32'(bus.cmd_ready), 32'd0);
    chk("bp_head", 32'(bus.rsp_data), 32'h81);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
    send(2'(OP_READ), 8'h00);
    drain();

    // CLEAR pulses reg_rst for one cycle
    send(2'(OP_WRITE), 8'hFF);
    send(2'(OP_CLEAR), 8'h77);
    chk("clr_pulse", 32'(reg_rst), 32'd1);
    chk("clr_no_wr", 32'(reg_w_en), 32'd0);
    @(posedge clk); #1;
    chk("clr_end", 32'(reg_rst), 32'd0);
    send(2'(OP_READ), 8'h00);
    drain();

    // Async reset during the capture cycle
    send(2'(OP_WRITE), 8'h5A);
    send(2'(OP_READ), 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    model_q = '0;
    #1;
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_reg_rst", 32'(reg_rst), 32'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_rel1_reg_rst", 32'(reg_rst), 32'd1);
    chk("mid_rel1_ready", 32'(bus.cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rel2_reg_rst", 32'(reg_rst), 32'd0);
    chk("mid_rsp_quiet", 32'(bus.rsp_valid), 32'd0);
    send(2'(OP_READ), 8'h00);
    drain();

    // Random op stream with random rsp_ready
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        bus.rsp_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    rand_mode = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_access_sequencer.md
Name: reg_access_sequencer

Overview:
- Upstream driver and readback consumer for the team's single-entry read/write register stage (read-before-write, synchronous active-high clear).
- Accepts host commands over a valid/ready interface and drives the register's w_en/r_en/in/rst pins.
- Captures the register's read data at the correct cycle and returns it through a small response FIFO with a valid/ready handshake.

Parameters:
- WIDTH, 8, data width; must match the register stage width.
- RSP_DEPTH, 2, response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command this cycle.
- cmd_op  in  2  00 CLEAR, 01 WRITE, 10 READ, 11 SWAP (read old value and write new value on the same edge).
- cmd_data  in  WIDTH  write data for WRITE/SWAP; ignored otherwise.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  host pops the response.
- rsp_data  out  WIDTH  head-of-FIFO read data.
- reg_rst  out  1  to register stage rst; active-high, synchronous at the register.
- reg_w_en  out  1  to register stage w_en.
- reg_r_en  out  1  to register stage r_en.
- reg_in  out  WIDTH  to register stage in.
- reg_out  in  WIDTH  from register stage out; X whenever no read was issued on the prior edge.
- busy  out  1  a read is in flight or the FIFO is not empty.

Behaviour:
- Reset values while rst is low: reg_rst=1, reg_w_en=0, reg_r_en=0, reg_in=0, FIFO empty, rsp_valid=0, in-flight count=0, cmd_ready=0.
- First cycle after rst deasserts: reg_rst is still 1, so the register clears on that edge; cmd_ready=0. reg_rst=0 and cmd_ready is live from the second cycle onward.
- A handshake occurs when cmd_valid && cmd_ready at a posedge. All reg_* outputs are registered.
- Cycle after acceptance (issue cycle E), by op:
  - CLEAR: reg_rst=1.
  - WRITE: reg_w_en=1, reg_in=cmd_data.
  - READ: reg_r_en=1.
  - SWAP: reg_r_en=1, reg_w_en=1, reg_in=cmd_data.
- With no handshake, all enables are 0 in the next cycle and reg_in holds its last value.
- Read pipeline: the register loads out at the end of E, and reg_out is valid during E+1. The sequencer pushes reg_out into the FIFO at the end of E+1. rsp_valid rises in E+2, giving 2 cycles from issue to rsp_valid.
- SWAP returns the value held before the write (read priority). READ with no prior write after clear returns 0.
- Only READ/SWAP produce a response; WRITE/CLEAR produce none.
- Capture is driven only by a 2-stage pending-read shift (rd_p1, rd_p2). reg_out is never sampled when its pending bit is 0, so X is never propagated.
- Credit rule: inflight = rd_p1 + rd_p2. cmd_ready = !reset_hold && (fifo_count + inflight < RSP_DEPTH).
  - cmd_ready does not depend on cmd_valid or cmd_op, so it is conservative for WRITE/CLEAR.
  - The FIFO can therefore never overflow; the push-when-full case is unreachable and is asserted in the bench.
- FIFO: circular with ptr width clog2(RSP_DEPTH) plus 1 wrap bit. Full/empty are determined by comparing pointers and the wrap bit.
  - Simultaneous push and pop in the same cycle keeps the count unchanged, with rsp_data advancing to the next entry.
  - A pop when empty is ignored.
  - rsp_data is the head entry and holds its value while rsp_valid && !rsp_ready.
- Back-to-back commands: one per cycle while cmd_ready stays high, including READ, READ, which yields responses in consecutive cycles.
- Async reset mid-operation: in-flight reads and FIFO contents are discarded, no response is emitted, and the register is re-cleared via reg_rst.
- busy = rd_p1 | rd_p2 | rsp_valid.

Decomposition:
- Shared package reg_seq_pkg holds:
  - an op enum with OP_CLEAR=2'b00, OP_WRITE=2'b01, OP_READ=2'b10, OP_SWAP=2'b11;
  - a localparam for the read capture latency (2).
- One sub-module, reg_seq_rsp_fifo (WIDTH, DEPTH), implements the response buffer: push, pop, data, count, full, empty.
- Issue logic, the pending-read shift and the credit logic stay in the top module.

Test Plan:
- Release rst, then WRITE 0xA5, then READ: reg_w_en pulses with reg_in=0xA5; rsp_data=0xA5 with rsp_valid exactly 2 cycles after the reg_r_en cycle.
- WRITE 0x3C, then SWAP 0x81, then READ: responses are 0x3C then 0x81, in order.
- Hold rsp_ready=0 and issue READ x3 with RSP_DEPTH=2: cmd_ready drops after the 2nd acceptance. Raising rsp_ready restores it, and the 3rd response arrives correctly with no overflow.
- WRITE 0xFF, CLEAR, READ: reg_rst pulses for one cycle and the response is 0x00.
- Issue READ, then assert rst low in the capture cycle: after release rsp_valid=0, busy=0, reg_rst is high for the first cycle, and a following READ returns 0x00.
- Random op stream against a behavioural model of the register, with random rsp_ready: data always matches the model and reg_out is never sampled when it is X.
